// File: rtl/tinyqv_alu_seq.sv
// Word-level wrapper around the nibble-serial tinyqv_alu: takes a 32-bit op/a/b request,
// runs it LS nibble first over eight cycles, and returns the 32-bit result with final cy/cmp.

module tinyqv_alu (
  input  logic [3:0] op,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cy_in,
  input  logic       cmp_in,
  output logic [3:0] d,
  output logic       cy_out,
  output logic       cmp_out
);
  logic [3:0] b_add;
  logic [4:0] sum;

  always_comb begin
    // SUB/SLT/SLTU subtract as a + ~b + 1, the +1 arriving through cy_in on nibble 0
    b_add = (op[1] | op[3]) ? ~b : b;
    sum   = {1'b0, a} + {1'b0, b_add} + {4'b0, cy_in};
    cy_out = sum[4];
    case (op[2:0])
      3'b111:  d = a & b;
      3'b110:  d = a | b;
      3'b100:  d = a ^ b;
      default: d = sum[3:0];
    endcase
    // Every nibble produces a provisional compare; only the last one is meaningful for SLT
    if (op[1])
      cmp_out = (op[0] || (a[3] == b[3])) ? ~sum[4] : a[3];
    else
      cmp_out = cmp_in & (a == b);
  end
endmodule

module tinyqv_alu_seq #(
  parameter bit BACK_TO_BACK = 1'b1
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_d,
  output logic        out_cy,
  output logic        out_cmp
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  cnt;
  logic [3:0]  op_r;
  logic [31:0] a_r, b_r, d_r;
  logic        cy_r, cmp_r;
  logic        accept;
  logic        alu_cy_in, alu_cmp_in, alu_cy, alu_cmp;
  logic [3:0]  alu_d;

  assign in_ready = rstn & ~flush &
                    ((state == IDLE) | (BACK_TO_BACK && (state == RESP) && out_ready));
  assign accept   = in_valid & in_ready;

  assign alu_cy_in  = (cnt == 3'd0) ? (op_r[1] | op_r[3]) : cy_r;
  assign alu_cmp_in = (cnt == 3'd0) | cmp_r;

  tinyqv_alu u_alu (
    .op      (op_r),
    .a       (a_r[3:0]),
    .b       (b_r[3:0]),
    .cy_in   (alu_cy_in),
    .cmp_in  (alu_cmp_in),
    .d       (alu_d),
    .cy_out  (alu_cy),
    .cmp_out (alu_cmp)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (cnt == 3'd7) state_nxt = RESP;
      RESP:    if (out_ready) state_nxt = accept ? BUSY : IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nxt;
  end

  // Operands shift right one nibble per cycle; result nibbles enter at the top so that
  // after eight cycles nibble 0 has arrived at d_r[3:0].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= 3'd0;
      op_r  <= 4'd0;
      a_r   <= 32'd0;
      b_r   <= 32'd0;
      d_r   <= 32'd0;
      cy_r  <= 1'b0;
      cmp_r <= 1'b0;
    end else if (flush) begin
      cnt <= 3'd0;
    end else if (accept) begin
      op_r <= in_op;
      a_r  <= in_a;
      b_r  <= in_b;
      cnt  <= 3'd0;
    end else if (state == BUSY) begin
      a_r   <= {4'd0, a_r[31:4]};
      b_r   <= {4'd0, b_r[31:4]};
      d_r   <= {alu_d, d_r[31:4]};
      cy_r  <= alu_cy;
      cmp_r <= alu_cmp;
      cnt   <= cnt + 3'd1;
    end
  end

  assign out_valid = (state == RESP);
  assign out_d     = d_r;
  assign out_cy    = cy_r;
  assign out_cmp   = cmp_r;
endmodule
